// File: rtl/segway_pkg.sv
// Shared command codes and authorisation states for the Segway command path.
// Pure declarations: no logic, no latency.
// No flow control here; consumers apply their own handshakes.
package segway_pkg;

    localparam logic [7:0] CMD_GO   = 8'h67;
    localparam logic [7:0] CMD_STOP = 8'h73;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        PWR1 = 2'd1,
        PWR2 = 2'd2
    } auth_state_t;

endpackage

// File: rtl/auth_wdog.sv
// Heartbeat watchdog: counts clocks while running, restarted by each kick.
// expire is a combinational compare on the registered count (0-cycle decode).
// No backpressure; the counter clears itself at expiry so it can never wrap.
module auth_wdog #(
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic kick,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_wd_cnt;

    assign expire = run & (r_wd_cnt == LAST_CNT);

    // Count while running; hold at zero when idle, on a kick, or at the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt <= '0;
        end else if (!run || kick || expire) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/auth_cmd_blk.sv
// Consumes UART bytes once, decodes go/stop, and authorises balancing via pwr_up.
// Latency: byte acceptance to clr_rdy / pwr_up / bad_cmd is 1 clock.
// Backpressure: none; a byte is taken the first cycle rdy is seen, clr_rdy acks it.
module auth_cmd_blk
    import segway_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rdy,
    input  logic [7:0] cmd,
    input  logic       rider_off,
    output logic       clr_rdy,
    output logic       pwr_up,
    output logic       bad_cmd,
    output logic       hb_timeout
);

    auth_state_t r_state;
    auth_state_t w_nxt_state;
    logic        r_clr_rdy;
    logic        r_pwr_up;
    logic        r_bad_cmd;
    logic        r_hb_timeout;

    logic w_byte_acc;
    logic w_go;
    logic w_stop;
    logic w_wd_expire;
    logic w_tmo;

    // rdy stays high during the ack cycle, so masking with clr_rdy keeps it single-shot.
    assign w_byte_acc = rdy & ~r_clr_rdy;
    assign w_go       = w_byte_acc & (cmd == CMD_GO);
    assign w_stop     = w_byte_acc & (cmd == CMD_STOP);

    // A real byte in the expiry cycle takes precedence over the timeout.
    assign w_tmo = w_wd_expire & ~w_go & ~w_stop;

    auth_wdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (r_state == PWR1),
        .kick  (w_go),
        .expire(w_wd_expire)
    );

    // Next-state decode; a watchdog timeout in PWR1 behaves exactly like a stop.
    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            OFF: begin
                if (w_go) w_nxt_state = PWR1;
            end
            PWR1: begin
                if (w_stop || w_tmo) w_nxt_state = rider_off ? OFF : PWR2;
            end
            PWR2: begin
                if (w_go)           w_nxt_state = PWR1;
                else if (rider_off) w_nxt_state = OFF;
            end
            default: w_nxt_state = OFF;
        endcase
    end

    // Byte handshake: ack and bad-byte flag, both one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_rdy <= 1'b0;
            r_bad_cmd <= 1'b0;
        end else begin
            r_clr_rdy <= w_byte_acc;
            r_bad_cmd <= w_byte_acc & ~w_go & ~w_stop;
        end
    end

    // Authorisation FSM with registered outputs loaded on the state edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= OFF;
            r_pwr_up     <= 1'b0;
            r_hb_timeout <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_pwr_up     <= (w_nxt_state != OFF);
            r_hb_timeout <= w_tmo;
        end
    end

    assign clr_rdy    = r_clr_rdy;
    assign pwr_up     = r_pwr_up;
    assign bad_cmd    = r_bad_cmd;
    assign hb_timeout = r_hb_timeout;

endmodule

// File: tb/tb_auth_cmd_blk.sv
module tb_auth_cmd_blk;
    import segway_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rdy = 1'b0;
    logic [7:0] cmd = 8'h00;
    logic       rider_off = 1'b0;
    logic       clr_rdy;
    logic       pwr_up;
    logic       bad_cmd;
    logic       hb_timeout;

    auth_cmd_blk #(.TIMEOUT_CYC(100)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rdy       (rdy),
        .cmd       (cmd),
        .rider_off (rider_off),
        .clr_rdy   (clr_rdy),
        .pwr_up    (pwr_up),
        .bad_cmd   (bad_cmd),
        .hb_timeout(hb_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pwr;
        logic        bad;
        auth_state_t st;
    } exp_t;

    typedef struct {
        logic [7:0] c;
        logic       ro;
        exp_t       e;
    } vec_t;

    int   n_tot = 0;
    int   n_bad = 0;
    int   n_clr = 0;
    int   n_sent = 0;
    int   n_tmo = 0;
    exp_t sb_q[$];
    logic prev_clr = 1'b0;

    task automatic check(input string nm, input int act, input int req);
        n_tot++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic exp_t mk_exp(input logic p, input logic b, input auth_state_t s);
        exp_t e;
        e.pwr = p;
        e.bad = b;
        e.st  = s;
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic [7:0] c, input logic ro,
                                    input logic p, input logic b, input auth_state_t s);
        vec_t v;
        v.c  = c;
        v.ro = ro;
        v.e  = mk_exp(p, b, s);
        return v;
    endfunction

    // Scoreboard: every ack pops one expected record and checks the outputs of that cycle.
    always @(negedge clk) begin
        exp_t e;
        if (hb_timeout) n_tmo++;
        if (clr_rdy) begin
            n_clr++;
            check("clr_rdy_back_to_back", int'(prev_clr), 0);
            check("clr_rdy_has_pending_byte", int'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("byte_pwr_up", int'(pwr_up), int'(e.pwr));
                check("byte_bad_cmd", int'(bad_cmd), int'(e.bad));
                check("byte_state", int'(dut.r_state), int'(e.st));
            end
        end else if (rst_n) begin
            check("bad_cmd_without_ack", int'(bad_cmd), 0);
        end
        prev_clr = clr_rdy;
    end

    // Present one byte: rdy high in the accept cycle and the ack cycle, dropped after.
    task automatic send_byte(input logic [7:0] c, input logic ro, input exp_t e);
        @(negedge clk);
        rdy       = 1'b1;
        cmd       = c;
        rider_off = ro;
        sb_q.push_back(e);
        n_sent++;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rdy       = 1'b0;
        cmd       = 8'h00;
        rider_off = 1'b0;
    endtask

    // Watch the cycles after a 'g' (already returned from send_byte) for the expiry pulse.
    task automatic watch_expiry(input string nm, input logic exp_pwr, input auth_state_t exp_st);
        for (int k = 2; k <= 104; k++) begin
            @(posedge clk);
            @(negedge clk);
            check({nm, "_hb_timeout"}, int'(hb_timeout), int'(k == 100));
            if (k == 100) begin
                check({nm, "_pwr_up"}, int'(pwr_up), int'(exp_pwr));
                check({nm, "_state"}, int'(dut.r_state), int'(exp_st));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_time_guard: run did not finish, got %0d checks", n_tot);
        $fatal(1);
    end

    vec_t tbl[14];
    int   tmo_base;

    initial begin
        tbl[0]  = mk_vec(8'h73, 1'b0, 1'b0, 1'b0, OFF);   // stop ignored in OFF
        tbl[1]  = mk_vec(8'h41, 1'b0, 1'b0, 1'b1, OFF);   // bad byte in OFF
        tbl[2]  = mk_vec(8'h67, 1'b0, 1'b1, 1'b0, PWR1);  // go
        tbl[3]  = mk_vec(8'h41, 1'b0, 1'b1, 1'b1, PWR1);  // bad byte in PWR1
        tbl[4]  = mk_vec(8'h67, 1'b0, 1'b1, 1'b0, PWR1);  // go in PWR1 stays
        tbl[5]  = mk_vec(8'h73, 1'b0, 1'b1, 1'b0, PWR2);  // stop, rider aboard
        tbl[6]  = mk_vec(8'h41, 1'b0, 1'b1, 1'b1, PWR2);  // bad byte in PWR2
        tbl[7]  = mk_vec(8'h67, 1'b0, 1'b1, 1'b0, PWR1);  // go from PWR2
        tbl[8]  = mk_vec(8'h73, 1'b1, 1'b0, 1'b0, OFF);   // stop, rider off
        tbl[9]  = mk_vec(8'h67, 1'b0, 1'b1, 1'b0, PWR1);
        tbl[10] = mk_vec(8'h73, 1'b0, 1'b1, 1'b0, PWR2);
        tbl[11] = mk_vec(8'h67, 1'b1, 1'b1, 1'b0, PWR1);  // go beats rider_off in PWR2
        tbl[12] = mk_vec(8'h73, 1'b0, 1'b1, 1'b0, PWR2);
        tbl[13] = mk_vec(8'h73, 1'b0, 1'b1, 1'b0, PWR2);  // stop again in PWR2 holds

        // Reset state
        #1;
        check("rst_clr_rdy", int'(clr_rdy), 0);
        check("rst_pwr_up", int'(pwr_up), 0);
        check("rst_bad_cmd", int'(bad_cmd), 0);
        check("rst_hb_timeout", int'(hb_timeout), 0);
        check("rst_state", int'(dut.r_state), int'(OFF));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            send_byte(tbl[i].c, tbl[i].ro, tbl[i].e);
        end

        // PWR2 then rider steps off: power drops the next clock
        @(negedge clk);
        check("pwr2_hold_pwr_up", int'(pwr_up), 1);
        rider_off = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("pwr2_rider_off_pwr_up", int'(pwr_up), 0);
        check("pwr2_rider_off_state", int'(dut.r_state), int'(OFF));
        rider_off = 1'b0;

        // Expiry with rider off: straight to OFF
        send_byte(CMD_GO, 1'b0, mk_exp(1'b1, 1'b0, PWR1));
        rider_off = 1'b1;
        watch_expiry("tmo_rider_off", 1'b0, OFF);
        rider_off = 1'b0;

        // Expiry with rider aboard: PWR2, then rider leaves
        send_byte(CMD_GO, 1'b0, mk_exp(1'b1, 1'b0, PWR1));
        watch_expiry("tmo_rider_on", 1'b1, PWR2);
        @(negedge clk);
        rider_off = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("tmo_cleanup_state", int'(dut.r_state), int'(OFF));
        rider_off = 1'b0;

        // Heartbeat every 90 clocks, then go and stop landing exactly on the expiry cycle
        tmo_base = n_tmo;
        send_byte(CMD_GO, 1'b0, mk_exp(1'b1, 1'b0, PWR1));
        for (int i = 0; i < 11; i++) begin
            repeat (88) @(posedge clk);
            send_byte(CMD_GO, 1'b0, mk_exp(1'b1, 1'b0, PWR1));
        end
        check("kick90_no_timeout", n_tmo - tmo_base, 0);
        repeat (98) @(posedge clk);
        send_byte(CMD_GO, 1'b0, mk_exp(1'b1, 1'b0, PWR1));
        check("go_at_expiry_no_timeout", n_tmo - tmo_base, 0);
        repeat (98) @(posedge clk);
        send_byte(CMD_STOP, 1'b0, mk_exp(1'b1, 1'b0, PWR2));
        check("stop_at_expiry_no_timeout", n_tmo - tmo_base, 0);
        repeat (150) @(posedge clk);
        @(negedge clk);
        check("pwr2_idle_no_timeout", n_tmo - tmo_base, 0);
        check("pwr2_idle_state", int'(dut.r_state), int'(PWR2));
        check("pwr2_idle_pwr_up", int'(pwr_up), 1);

        // Go from PWR2, then async reset mid-PWR1
        send_byte(CMD_GO, 1'b0, mk_exp(1'b1, 1'b0, PWR1));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pwr_up", int'(pwr_up), 0);
        check("async_rst_state", int'(dut.r_state), int'(OFF));

        // Byte already waiting across reset release is taken normally
        @(negedge clk);
        rdy = 1'b1;
        cmd = CMD_GO;
        sb_q.push_back(mk_exp(1'b1, 1'b0, PWR1));
        n_sent++;
        @(negedge clk);
        check("in_rst_no_ack", n_clr, n_sent - 1);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rdy = 1'b0;
        cmd = 8'h00;
        check("post_rst_pwr_up", int'(pwr_up), 1);

        @(negedge clk);
        check("acks_match_bytes", n_clr, n_sent);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
